apb_req_queue: RTL

- Command sequencer directly upstream of the APB master; feeds its PWRITE_MASTER / PADDR_MASTER / PWDATA_MASTER inputs.
- Buffers host requests in a FIFO and presents one command at a time, holding it until the bus shows a completed access phase.
- Returns read data or error status to the host as a one-cycle response strobe, so software-style stimulus replaces hand-timed two-edge sequencing.

---
 rtl/apb_req_queue_pkg.sv | 28 ++
 rtl/apb_req_queue_cmd_fifo.sv | 59 +++++
 rtl/apb_req_queue.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/apb_req_queue_pkg.sv
// Shared types and defaults for the APB command sequencer and its command FIFO.
// Command fields are sized for the widest supported bus (32-bit address and data).
package apb_req_pkg;

  localparam int DEF_DEPTH          = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam int CMD_AW             = 32;
  localparam int CMD_DW             = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic              write;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
  } apb_cmd_t;

  // Read data is only meaningful for a read that completed on the bus.
  function automatic logic [CMD_DW-1:0] rsp_data(input logic ok, input logic write,
                                                 input logic [CMD_DW-1:0] rdata);
    return (ok && !write) ? rdata : '0;
  endfunction

endpackage

// File: rtl/apb_req_queue_cmd_fifo.sv
// Synchronous command FIFO; head and the entry behind it are visible combinationally.
// Pushes while full and pops while empty are ignored; occupancy updates on the edge.
module apb_cmd_fifo
  import apb_req_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  apb_cmd_t              i_dat,
  input  logic                  i_pop,
  output apb_cmd_t              o_head,
  output apb_cmd_t              o_next,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int PW = $clog2(DEPTH);

  apb_cmd_t        r_mem [DEPTH];
  logic [PW:0]     r_wr_ptr;
  logic [PW:0]     r_rd_ptr;
  logic [PW-1:0]   w_next_idx;
  logic            w_push;
  logic            w_pop;

  // The extra pointer bit separates full from empty when the indices match.
  assign o_level    = r_wr_ptr - r_rd_ptr;
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (o_level == (PW+1)'(DEPTH));
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;
  assign w_next_idx = r_rd_ptr[PW-1:0] + PW'(1);
  assign o_head     = r_mem[r_rd_ptr[PW-1:0]];
  assign o_next     = r_mem[w_next_idx];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PW-1:0]] <= i_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/apb_req_queue.sv
// Queues host commands and presents one at a time to the APB master; command appears one edge after an idle push.
// REQ_READY is registered !full with no bypass; responses are one-cycle strobes with no back-pressure.
module apb_req_queue
  import apb_req_pkg::*;
#(
  parameter int DEPTH          = DEF_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int AW             = CMD_AW,
  parameter int DW             = CMD_DW
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   REQ_VALID,
  output logic                   REQ_READY,
  input  logic                   REQ_WRITE,
  input  logic [AW-1:0]          REQ_ADDR,
  input  logic [DW-1:0]          REQ_WDATA,
  output logic                   PWRITE_MASTER,
  output logic [AW-1:0]          PADDR_MASTER,
  output logic [DW-1:0]          PWDATA_MASTER,
  input  logic [DW-1:0]          PRDATA_MASTER,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PREADY,
  output logic                   RSP_VALID,
  output logic                   RSP_WRITE,
  output logic                   RSP_ERR,
  output logic [DW-1:0]          RSP_RDATA,
  output logic                   BUSY,
  output logic [$clog2(DEPTH):0] LEVEL
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  apb_cmd_t      w_push_cmd;
  apb_cmd_t      w_head;
  apb_cmd_t      w_next;
  apb_cmd_t      w_load_cmd;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_hit;
  logic          w_tmo;
  logic          w_retire;
  logic [LW-1:0] w_level;
  logic [LW-1:0] w_level_nxt;

  fsm_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_req_ready;
  logic          r_pwrite;
  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pwdata;
  logic          r_rsp_vld;
  logic          r_rsp_write;
  logic          r_rsp_err;
  logic [DW-1:0] r_rsp_rdata;

  always_comb begin
    w_push_cmd       = '0;
    w_push_cmd.write = REQ_WRITE;
    w_push_cmd.addr  = CMD_AW'(REQ_ADDR);
    w_push_cmd.wdata = CMD_DW'(REQ_WDATA);
  end

  assign w_push      = REQ_VALID & r_req_ready & ~w_full;
  assign w_hit       = PSEL & PENABLE & PREADY;
  assign w_tmo       = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_retire    = (r_state == WAIT) & (w_hit | w_tmo);
  assign w_pop       = w_retire;
  assign w_level_nxt = w_level + LW'(w_push) - LW'(w_pop);

  // On a retire the head is the command being retired, so the follower comes from the next slot.
  assign w_load_cmd  = (r_state == WAIT) ? w_next : w_head;

  apb_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (PCLK),
    .i_rst   (PRESET),
    .i_push  (w_push),
    .i_dat   (w_push_cmd),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_vld   <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_req_ready <= (w_level_nxt != LW'(DEPTH));
      r_rsp_vld   <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_pwrite <= w_load_cmd.write;
            r_paddr  <= w_load_cmd.addr[AW-1:0];
            r_pwdata <= w_load_cmd.wdata[DW-1:0];
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_retire) begin
            r_rsp_vld   <= 1'b1;
            r_rsp_write <= r_pwrite;
            r_rsp_err   <= ~w_hit;
            r_rsp_rdata <= DW'(rsp_data(w_hit, r_pwrite, CMD_DW'(PRDATA_MASTER)));
            // A command pushed on this same edge is not yet readable; IDLE picks it up next cycle.
            if (w_level > LW'(1)) begin
              r_pwrite <= w_load_cmd.write;
              r_paddr  <= w_load_cmd.addr[AW-1:0];
              r_pwdata <= w_load_cmd.wdata[DW-1:0];
              r_state  <= ISSUE;
            end else begin
              r_pwrite <= 1'b0;
              r_state  <= IDLE;
            end
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign REQ_READY     = r_req_ready;
  assign PWRITE_MASTER = r_pwrite;
  assign PADDR_MASTER  = r_paddr;
  assign PWDATA_MASTER = r_pwdata;
  assign RSP_VALID     = r_rsp_vld;
  assign RSP_WRITE     = r_rsp_write;
  assign RSP_ERR       = r_rsp_err;
  assign RSP_RDATA     = r_rsp_rdata;
  assign LEVEL         = w_level;
  // Held high through the response strobe so it drops the cycle after the last one.
  assign BUSY          = (r_state != IDLE) | ~w_empty | r_rsp_vld;

endmodule
